mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 4: SRAM cycles per access, legal range 1..15.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports if_req  input  1  fetch read request, level, held until if_ready; and if_addr  input  32  fetch byte address.
REQ-005 SHALL have ports if_rdata  output  32  fetched word; if_ready  output  1  one-cycle completion pulse; if_stall  output  1  freeze fetch.
REQ-006 SHALL have ports mem_rd_req  input  1; mem_wr_req  input  1; mem_addr  input  32; mem_wdata  input  32: MEM-stage load/store requests, level.
REQ-007 SHALL have ports mem_rdata  output  32; mem_ready  output  1  one-cycle pulse; mem_stall  output  1  freeze pipeline.
REQ-008 SHALL have ports sram_addr  output  30  word address; sram_wdata  output  32; sram_we  output  1; sram_oe  output  1; sram_rdata  input  32.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-010 In IDLE, on a rising edge with any request pending, SHALL capture the winner's address, data and direction, then enter ACCESS.
REQ-011 Arbitration SHALL be fixed priority: MEM request over IF request; the loser stays pending.
REQ-012 mem_wr_req and mem_rd_req both high SHALL be treated as a write; mem_rdata unchanged.
REQ-013 ACCESS SHALL last exactly WAIT_CYCLES cycles, timed by a down-counter loaded with WAIT_CYCLES-1.
REQ-014 During ACCESS, sram_addr SHALL equal the captured addr[31:2], held constant; sram_wdata SHALL equal the captured wdata.
REQ-015 During ACCESS, sram_we SHALL be 1 for writes; sram_oe SHALL be 1 for reads; both SHALL be 0 in IDLE and RESP.
REQ-016 On the last ACCESS cycle, a read SHALL latch sram_rdata into the granted requester's rdata register.
REQ-017 The FSM SHALL then enter RESP for one cycle, asserting only the granted requester's ready. RESP SHALL always return to IDLE; requests are not sampled in RESP.
REQ-018 Latency SHALL be fixed: with the request sampled in IDLE at cycle 0, ready SHALL be high in cycle WAIT_CYCLES+1; back-to-back throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-019 if_stall SHALL equal if_req AND NOT if_ready, combinational.
REQ-020 mem_stall SHALL equal (mem_rd_req OR mem_wr_req) AND NOT mem_ready, combinational.
REQ-021 A request withdrawn or changed mid-access SHALL NOT alter the captured access; the access SHALL still complete and pulse ready.
REQ-022 if_rdata and mem_rdata SHALL hold their values between reads.

Reset
REQ-023 rst low SHALL immediately force state IDLE and counter 0.
REQ-024 rst low SHALL immediately force sram_addr, sram_wdata, if_rdata and mem_rdata to 0, and sram_we, sram_oe, if_ready and mem_ready to 0.
REQ-025 Reset mid-access SHALL abandon the access with no ready pulse; requests still held after release SHALL be re-arbitrated from IDLE.

Structure
REQ-026 Package arb_pkg SHALL hold the state enum, the grant enum (GRANT_IF, GRANT_MEM) and the WAIT_CYCLES legal-range constants.
REQ-027 Sub-module access_timer SHALL be the loadable down-counter with a done flag; all other logic SHALL be flat.

Verification (WAIT_CYCLES=4 unless stated)
REQ-028 IF read: if_req=1, if_addr=0x00000008, sram_rdata=0xE3A00005 -> sram_addr=0x2 with oe high cycles 1-4, if_ready cycle 5, if_rdata=0xE3A00005, if_stall high cycles 0-4.
REQ-029 Contention: if_req and mem_rd_req (addr 0x400) both rise at cycle 0 -> sram_addr=0x100 and mem_ready at cycle 5; IF served cycles 7-10 with if_ready at cycle 11.
REQ-030 Store: mem_wr_req=1, mem_addr=0x404, mem_wdata=0xDEADBEEF -> sram_we high cycles 1-4 with sram_addr=0x101 and wdata held, oe low throughout, mem_ready cycle 5.
REQ-031 Reset: rst low in cycle 2 of ACCESS -> all outputs 0 asynchronously, no ready pulse; held request after release completes a fresh full-latency access.
REQ-032 Conflict: mem_rd_req=mem_wr_req=1 -> write performed (we high, oe low), mem_rdata unchanged.
REQ-033 WAIT_CYCLES=1, continuous mem_rd_req -> mem_ready pulses every 3rd cycle, if_req starved while MEM is held, served when MEM drops.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    typedef enum logic {
        GRANT_IF,
        GRANT_MEM
    } grant_e;

    localparam int unsigned WAIT_MIN = 1;
    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/access_timer.sv
// Loadable down-counter that times one SRAM access; done while the count is zero.
module access_timer
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one slow SRAM between instruction fetch and
// the MEM stage; MEM always wins, each access takes WAIT_CYCLES plus a response cycle.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        mem_rd_req,
    input  logic        mem_wr_req,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic [29:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic        sram_we,
    output logic        sram_oe,
    input  logic [31:0] sram_rdata
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_e      state_q;
    grant_e      grant_q;
    logic [29:0] sram_addr_q;
    logic [31:0] sram_wdata_q;
    logic        sram_we_q;
    logic        sram_oe_q;
    logic [31:0] if_rdata_q;
    logic [31:0] mem_rdata_q;
    logic        if_ready_q;
    logic        mem_ready_q;

    logic mem_any;
    logic timer_load;
    logic timer_done;
    logic unused_addr_bits;

    assign mem_any          = mem_rd_req | mem_wr_req;
    assign timer_load       = (state_q == S_IDLE) && (mem_any || if_req);
    assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};

    access_timer u_timer (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (timer_load),
        .load_val_i (LOAD_VAL),
        .done_o     (timer_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= GRANT_IF;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            sram_oe_q    <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_any) begin
                        // A simultaneous read and write request is performed as a write.
                        grant_q      <= GRANT_MEM;
                        sram_addr_q  <= mem_addr[31:2];
                        sram_wdata_q <= mem_wdata;
                        sram_we_q    <= mem_wr_req;
                        sram_oe_q    <= ~mem_wr_req;
                        state_q      <= S_ACCESS;
                    end else if (if_req) begin
                        grant_q      <= GRANT_IF;
                        sram_addr_q  <= if_addr[31:2];
                        sram_wdata_q <= '0;
                        sram_we_q    <= 1'b0;
                        sram_oe_q    <= 1'b1;
                        state_q      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (timer_done) begin
                        if (sram_oe_q) begin
                            if (grant_q == GRANT_MEM) begin
                                mem_rdata_q <= sram_rdata;
                            end else begin
                                if_rdata_q <= sram_rdata;
                            end
                        end
                        sram_we_q   <= 1'b0;
                        sram_oe_q   <= 1'b0;
                        if_ready_q  <= (grant_q == GRANT_IF);
                        mem_ready_q <= (grant_q == GRANT_MEM);
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if_ready_q  <= 1'b0;
                    mem_ready_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_we    = sram_we_q;
    assign sram_oe    = sram_oe_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_ready   = if_ready_q;
    assign mem_ready  = mem_ready_q;
    assign if_stall   = if_req & ~if_ready_q;
    assign mem_stall  = mem_any & ~mem_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_CYCLES 4 and 1) share one stimulus
// stream and are compared against a transaction-level timing model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] sram_rdata;

    logic [1:0][31:0] d_if_rdata;
    logic [1:0][31:0] d_mem_rdata;
    logic [1:0][31:0] d_sram_wdata;
    logic [1:0][29:0] d_sram_addr;
    logic [1:0]       d_if_ready;
    logic [1:0]       d_if_stall;
    logic [1:0]       d_mem_ready;
    logic [1:0]       d_mem_stall;
    logic [1:0]       d_sram_we;
    logic [1:0]       d_sram_oe;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: per instance, whether a transaction is in flight and
    // how many cycles have elapsed since its capture edge.
    bit          busy[2];
    int          ph[2];
    bit          gmem[2];
    bit          wr[2];
    logic [29:0] m_addr[2];
    logic [31:0] m_wdata[2];
    logic [31:0] m_if_rd[2];
    logic [31:0] m_mem_rd[2];

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(d_if_rdata[0]),
        .if_ready(d_if_ready[0]), .if_stall(d_if_stall[0]),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(d_mem_rdata[0]),
        .mem_ready(d_mem_ready[0]), .mem_stall(d_mem_stall[0]),
        .sram_addr(d_sram_addr[0]), .sram_wdata(d_sram_wdata[0]),
        .sram_we(d_sram_we[0]), .sram_oe(d_sram_oe[0]), .sram_rdata(sram_rdata)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(d_if_rdata[1]),
        .if_ready(d_if_ready[1]), .if_stall(d_if_stall[1]),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(d_mem_rdata[1]),
        .mem_ready(d_mem_ready[1]), .mem_stall(d_mem_stall[1]),
        .sram_addr(d_sram_addr[1]), .sram_wdata(d_sram_wdata[1]),
        .sram_we(d_sram_we[1]), .sram_oe(d_sram_oe[1]), .sram_rdata(sram_rdata)
    );

    function automatic int wcyc(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; ph[k] = 0; gmem[k] = 0; wr[k] = 0;
            m_addr[k] = '0; m_wdata[k] = '0; m_if_rd[k] = '0; m_mem_rd[k] = '0;
        end
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            if (busy[k]) begin
                if (ph[k] == wcyc(k) && !wr[k]) begin
                    if (gmem[k]) m_mem_rd[k] = sram_rdata;
                    else         m_if_rd[k]  = sram_rdata;
                end
                if (ph[k] == wcyc(k) + 1) busy[k] = 0;
                else                      ph[k]++;
            end else if (mem_rd_req || mem_wr_req) begin
                a = mem_addr;
                busy[k] = 1; ph[k] = 1; gmem[k] = 1; wr[k] = mem_wr_req;
                m_addr[k] = a[31:2]; m_wdata[k] = mem_wdata;
            end else if (if_req) begin
                a = if_addr;
                busy[k] = 1; ph[k] = 1; gmem[k] = 0; wr[k] = 0;
                m_addr[k] = a[31:2]; m_wdata[k] = '0;
            end
        end
    endtask

    task automatic check_all();
        bit acc, rdy;
        for (int k = 0; k < 2; k++) begin
            acc = busy[k] && ph[k] <= wcyc(k);
            rdy = busy[k] && ph[k] == wcyc(k) + 1;
            check($sformatf("sram_addr[%0d]", k), 32'(d_sram_addr[k]), 32'(m_addr[k]));
            check($sformatf("sram_wdata[%0d]", k), d_sram_wdata[k], m_wdata[k]);
            check($sformatf("sram_we[%0d]", k), 32'(d_sram_we[k]), 32'(acc && wr[k]));
            check($sformatf("sram_oe[%0d]", k), 32'(d_sram_oe[k]), 32'(acc && !wr[k]));
            check($sformatf("if_ready[%0d]", k), 32'(d_if_ready[k]), 32'(rdy && !gmem[k]));
            check($sformatf("mem_ready[%0d]", k), 32'(d_mem_ready[k]), 32'(rdy && gmem[k]));
            check($sformatf("if_rdata[%0d]", k), d_if_rdata[k], m_if_rd[k]);
            check($sformatf("mem_rdata[%0d]", k), d_mem_rdata[k], m_mem_rd[k]);
            check($sformatf("if_stall[%0d]", k), 32'(d_if_stall[k]),
                  32'(if_req && !(rdy && !gmem[k])));
            check($sformatf("mem_stall[%0d]", k), 32'(d_mem_stall[k]),
                  32'((mem_rd_req || mem_wr_req) && !(rdy && gmem[k])));
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_in(input bit ir, input logic [31:0] ia, input bit mr, input bit mw,
                          input logic [31:0] ma, input logic [31:0] md, input logic [31:0] sr);
        if_req = ir; if_addr = ia; mem_rd_req = mr; mem_wr_req = mw;
        mem_addr = ma; mem_wdata = md; sram_rdata = sr;
    endtask

    int cnt_m4, cnt_m1, cnt_i1;

    initial begin
        set_in(0, '0, 0, 0, '0, '0, '0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // IF read with fixed latency
        set_in(1, 32'h8, 0, 0, '0, '0, 32'hE3A0_0005);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) begin
                check("if_rd_addr", 32'(d_sram_addr[0]), 32'h2);
                check("if_rd_oe", 32'(d_sram_oe[0]), 32'h1);
            end
            if (c == 5) begin
                check("if_rd_ready", 32'(d_if_ready[0]), 32'h1);
                check("if_rd_data", d_if_rdata[0], 32'hE3A0_0005);
                if_req = 0;
            end
        end
        do_reset();

        // Contention: MEM wins, IF waits
        set_in(1, 32'h20, 1, 0, 32'h400, 32'h0, 32'h1234_5678);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) check("cont_mem_addr", 32'(d_sram_addr[0]), 32'h100);
            if (c == 5) begin
                check("cont_mem_ready", 32'(d_mem_ready[0]), 32'h1);
                mem_rd_req = 0;
            end
            if (c == 7) check("cont_if_addr", 32'(d_sram_addr[0]), 32'h8);
            if (c == 11) begin
                check("cont_if_ready", 32'(d_if_ready[0]), 32'h1);
                if_req = 0;
            end
        end
        do_reset();

        // Store, then read+write conflict resolved as a write
        for (int s = 0; s < 2; s++) begin
            set_in(0, '0, s == 1, 1, 32'h404, 32'hDEAD_BEEF, 32'h5555_AAAA);
            for (int c = 1; c <= 6; c++) begin
                tick();
                if (c <= 4) begin
                    check("st_we", 32'(d_sram_we[0]), 32'h1);
                    check("st_oe", 32'(d_sram_oe[0]), 32'h0);
                    check("st_addr", 32'(d_sram_addr[0]), 32'h101);
                    check("st_wdata", d_sram_wdata[0], 32'hDEAD_BEEF);
                end
                if (c == 5) begin
                    check("st_ready", 32'(d_mem_ready[0]), 32'h1);
                    check("st_rdata", d_mem_rdata[0], 32'h0);
                    mem_rd_req = 0; mem_wr_req = 0;
                end
            end
        end

        // Reset mid-access abandons it; held request restarts with full latency
        do_reset();
        set_in(0, '0, 1, 0, 32'h80, '0, 32'hCAFE_0001);
        tick(); tick();
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c < 5) check("rst_no_ready", 32'(d_mem_ready[0]), 32'h0);
            if (c == 5) begin
                check("rst_fresh_ready", 32'(d_mem_ready[0]), 32'h1);
                check("rst_fresh_data", d_mem_rdata[0], 32'hCAFE_0001);
                mem_rd_req = 0;
            end
        end

        // Continuous MEM reads starve IF; throughput is one per WAIT_CYCLES+2
        do_reset();
        set_in(1, 32'h40, 1, 0, 32'h200, '0, 32'h0);
        cnt_m4 = 0; cnt_m1 = 0; cnt_i1 = 0;
        for (int c = 1; c <= 30; c++) begin
            sram_rdata = $urandom();
            tick();
            cnt_m4 += int'(d_mem_ready[0]);
            cnt_m1 += int'(d_mem_ready[1]);
            cnt_i1 += int'(d_if_ready[1]) + int'(d_if_ready[0]);
        end
        check("starve_mem_w1", 32'(cnt_m1), 32'd10);
        check("starve_mem_w4", 32'(cnt_m4), 32'd5);
        check("starve_if", 32'(cnt_i1), 32'd0);
        mem_rd_req = 0;
        for (int c = 1; c <= 10; c++) tick();
        if_req = 0;
        tick(); tick();

        // Random traffic, including withdrawn requests and occasional resets
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 5) == 0) if_req = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 5) == 0) begin
                    mem_rd_req = ($urandom_range(0, 2) == 0);
                    mem_wr_req = ($urandom_range(0, 3) == 0);
                end
                if ($urandom_range(0, 3) == 0) if_addr = $urandom();
                if ($urandom_range(0, 3) == 0) mem_addr = $urandom();
                if ($urandom_range(0, 3) == 0) mem_wdata = $urandom();
                sram_rdata = $urandom();
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
